// File: rtl/debug_ram_sequencer.sv
// debug_ram_sequencer: stream-driven loader/dumper for the core's debug DataRAM/InstRAM ports.
//   CPU_CLK, CPU_RST           clock, async active-high reset
//   cmd_*                      command: op (0 load / 1 dump), sel (0 data / 1 inst), base byte address, word count
//   wr_valid/wr_ready/wr_data  load word stream
//   rd_valid/rd_ready/rd_data/rd_addr  dump word stream with byte address
//   dram_*, iram_*             second BRAM ports (1-cycle read latency)
//   core_rst_hold              holds the core in reset while loading
//   busy, done                 status; done pulses once per completed command
module debug_ram_sequencer #(
  parameter int WORDS = 4096,
  parameter int CNT_W = 13
) (
  input  logic             CPU_CLK,
  input  logic             CPU_RST,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_op,
  input  logic             cmd_sel,
  input  logic [31:0]      cmd_base,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [31:0]      wr_data,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [31:0]      rd_data,
  output logic [31:0]      rd_addr,
  output logic [31:0]      dram_a2,
  output logic [31:0]      dram_wd2,
  output logic [3:0]       dram_we2,
  input  logic [31:0]      dram_rd2,
  output logic [31:0]      iram_a2,
  output logic [31:0]      iram_wd2,
  output logic [3:0]       iram_we2,
  input  logic [31:0]      iram_rd2,
  output logic             core_rst_hold,
  output logic             busy,
  output logic             done
);
  // word-aligned address mask; WORDS is a power of two so wrap is a mask
  localparam logic [31:0] AMASK = 32'(4 * WORDS - 1) & ~32'd3;
  typedef enum logic [2:0] {IDLE, LOAD, DUMP_ADDR, DUMP_WAIT, DUMP_OUT, FIN} state_t;
  state_t state, state_n;
  logic sel;
  logic [31:0] addr, addr_n, a2, wd2;
  logic [CNT_W-1:0] cnt;
  logic [3:0] we2;
  logic wr_hs, rd_hs, last;
  assign wr_hs  = state == LOAD && wr_valid;
  assign rd_hs  = state == DUMP_OUT && rd_ready;
  assign last   = cnt == CNT_W'(1);
  assign addr_n = (addr + 32'd4) & AMASK;
  always_comb begin
    state_n       = state;
    cmd_ready     = state == IDLE;
    busy          = state != IDLE;
    done          = state == FIN;
    core_rst_hold = state == LOAD;
    wr_ready      = state == LOAD;
    rd_valid      = state == DUMP_OUT;
    a2            = (wr_hs || state == DUMP_ADDR || state == DUMP_WAIT) ? addr : '0;
    wd2           = wr_hs ? wr_data : '0;
    we2           = wr_hs ? 4'hF : 4'h0;
    unique case (state)
      IDLE:      if (cmd_valid) state_n = cmd_count == '0 ? FIN : cmd_op ? DUMP_ADDR : LOAD;
      LOAD:      if (wr_hs && last) state_n = FIN;
      DUMP_ADDR: state_n = DUMP_WAIT;
      DUMP_WAIT: state_n = DUMP_OUT;
      DUMP_OUT:  if (rd_hs) state_n = last ? FIN : DUMP_ADDR;
      FIN:       state_n = IDLE;
      default:   state_n = IDLE;
    endcase
  end
  // only the selected port ever sees a non-zero address or data
  assign dram_a2  = sel ? '0 : a2;
  assign dram_wd2 = sel ? '0 : wd2;
  assign dram_we2 = sel ? '0 : we2;
  assign iram_a2  = sel ? a2 : '0;
  assign iram_wd2 = sel ? wd2 : '0;
  assign iram_we2 = sel ? we2 : '0;
  always_ff @(posedge CPU_CLK or posedge CPU_RST) begin
    if (CPU_RST) begin
      state   <= IDLE;
      sel     <= 1'b0;
      addr    <= '0;
      cnt     <= '0;
      rd_data <= '0;
      rd_addr <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && cmd_valid) begin
        sel  <= cmd_sel;
        addr <= cmd_base & AMASK;
        cnt  <= cmd_count;
      end
      if (wr_hs || rd_hs) begin
        addr <= addr_n;
        cnt  <= cnt - CNT_W'(1);
      end
      // address was presented in DUMP_ADDR, so rd2 is valid during DUMP_WAIT
      if (state == DUMP_WAIT) begin
        rd_data <= sel ? iram_rd2 : dram_rd2;
        rd_addr <= addr;
      end
    end
  end
endmodule

// File: tb/tb_debug_ram_sequencer.sv
// tb_debug_ram_sequencer: randomized bench with a transaction-level model of the sequencer.
module tb_debug_ram_sequencer;
  localparam int WORDS = 4096;
  localparam int CNT_W = 13;
  logic CPU_CLK = 0;
  logic CPU_RST = 1;
  logic cmd_valid = 0, cmd_op = 0, cmd_sel = 0;
  logic [31:0] cmd_base = 0;
  logic [CNT_W-1:0] cmd_count = 0;
  logic wr_valid = 0, rd_ready = 0;
  logic [31:0] wr_data = 0;
  logic cmd_ready, wr_ready, rd_valid, core_rst_hold, busy, done;
  logic [31:0] rd_data, rd_addr, dram_a2, dram_wd2, dram_rd2, iram_a2, iram_wd2, iram_rd2;
  logic [3:0] dram_we2, iram_we2;
  int vectors = 0, miscompares = 0;
  logic [31:0] words[$];
  logic [31:0] cap_a[$], cap_d[$];
  logic [31:0] ram_d[WORDS], ram_i[WORDS];

  debug_ram_sequencer #(.WORDS(WORDS), .CNT_W(CNT_W)) dut (
    .CPU_CLK(CPU_CLK), .CPU_RST(CPU_RST),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_sel(cmd_sel),
    .cmd_base(cmd_base), .cmd_count(cmd_count),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_addr(rd_addr),
    .dram_a2(dram_a2), .dram_wd2(dram_wd2), .dram_we2(dram_we2), .dram_rd2(dram_rd2),
    .iram_a2(iram_a2), .iram_wd2(iram_wd2), .iram_we2(iram_we2), .iram_rd2(iram_rd2),
    .core_rst_hold(core_rst_hold), .busy(busy), .done(done)
  );

  always #5 CPU_CLK = ~CPU_CLK;

  function automatic logic [31:0] init_word(input int s, input int i);
    return (s != 0 ? 32'hC0DE0000 : 32'hDA7A0000) ^ (32'(i) * 32'h9E3779B1);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // two BRAMs with 1-cycle read latency
  initial begin
    for (int i = 0; i < WORDS; i++) begin
      ram_d[i] = init_word(0, i);
      ram_i[i] = init_word(1, i);
    end
    forever begin
      @(posedge CPU_CLK);
      if (dram_we2 != 0) ram_d[dram_a2[13:2]] <= dram_wd2;
      if (iram_we2 != 0) ram_i[iram_a2[13:2]] <= iram_wd2;
      dram_rd2 <= ram_d[dram_a2[13:2]];
      iram_rd2 <= ram_i[iram_a2[13:2]];
    end
  end

  // transaction-level model: a pending command with remaining words and a next address
  initial begin
    logic active, due, nd, m_op, m_sel, hs_w, prv_stall;
    logic [31:0] m_addr, s_a2, s_wd2, u_a2, u_wd2;
    logic [3:0] s_we2, u_we2;
    logic [31:0] mm[2][WORDS];
    int rem, gap;
    active = 0; due = 0; m_op = 0; m_sel = 0; m_addr = 0; rem = 0; gap = 0; prv_stall = 0;
    for (int i = 0; i < WORDS; i++) begin
      mm[0][i] = init_word(0, i);
      mm[1][i] = init_word(1, i);
    end
    forever begin
      @(negedge CPU_CLK);
      if (CPU_RST) begin
        active = 0; due = 0; prv_stall = 0; gap = 0;
      end else begin
        hs_w  = active && !m_op && wr_valid;
        s_a2  = m_sel ? iram_a2 : dram_a2;
        s_wd2 = m_sel ? iram_wd2 : dram_wd2;
        s_we2 = m_sel ? iram_we2 : dram_we2;
        u_a2  = m_sel ? dram_a2 : iram_a2;
        u_wd2 = m_sel ? dram_wd2 : iram_wd2;
        u_we2 = m_sel ? dram_we2 : iram_we2;
        chk("cmd_ready", cmd_ready, !(active || due));
        chk("busy", busy, active || due);
        chk("done", done, due);
        chk("core_rst_hold", core_rst_hold, active && !m_op);
        chk("wr_ready", wr_ready, active && !m_op);
        if (active) begin
          chk("sel_we2", s_we2, hs_w ? 4'hF : 4'h0);
          chk("sel_wd2", s_wd2, hs_w ? wr_data : 32'h0);
          if (hs_w) chk("sel_a2", s_a2, m_addr);
          chk("unsel_a2", u_a2, 0);
          chk("unsel_wd2_we2", u_wd2 | {28'b0, u_we2}, 0);
        end else begin
          chk("idle_we2", {dram_we2, iram_we2}, 0);
          chk("idle_wd2", dram_wd2 | iram_wd2, 0);
        end
        if (active && m_op) begin
          if (prv_stall) chk("rd_hold", rd_valid, 1);
          if (rd_valid) begin
            chk("rd_addr", rd_addr, m_addr);
            chk("rd_data", rd_data, mm[m_sel][m_addr[13:2]]);
            gap = 0;
          end else begin
            gap++;
            chk("dump_gap", gap > 2, 0);
          end
        end else chk("rd_valid_idle", rd_valid, 0);
        prv_stall = rd_valid && !rd_ready;
        nd = 0;
        if (!active && !due && cmd_valid) begin
          if (cmd_count == 0) nd = 1;
          else begin
            active = 1; m_op = cmd_op; m_sel = cmd_sel; rem = int'(cmd_count); gap = 0;
            m_addr = (cmd_base & ~32'd3) % (4 * WORDS);
          end
        end else if (hs_w || (active && m_op && rd_valid && rd_ready)) begin
          if (hs_w) mm[m_sel][m_addr[13:2]] = wr_data;
          m_addr = (m_addr + 4) % (4 * WORDS);
          rem--;
          if (rem == 0) begin
            active = 0;
            nd = 1;
          end
        end
        due = nd;
      end
    end
  end

  task automatic wait_idle;
    int n = 0;
    while (busy && n < 50) begin
      @(posedge CPU_CLK); #1;
      n++;
    end
    if (busy) chk("idle_timeout", busy, 0);
  endtask

  task automatic send_cmd(input logic op, input logic sel, input logic [31:0] base, input int count);
    int n = 0;
    cmd_op = op; cmd_sel = sel; cmd_base = base; cmd_count = CNT_W'(count); cmd_valid = 1;
    do begin
      @(negedge CPU_CLK);
      n++;
    end while (!cmd_ready && n < 50);
    if (!cmd_ready) chk("cmd_timeout", cmd_ready, 1);
    @(posedge CPU_CLK); #1;
    cmd_valid = 0;
  endtask

  task automatic load(input logic sel, input logic [31:0] base, input int count,
                      input bit hold, input bit poke, output int cyc);
    int idx = 0;
    bit hs;
    cyc = 0;
    send_cmd(0, sel, base, count);
    while (idx < count && cyc < 20 * count + 20) begin
      wr_valid = hold || ($urandom_range(0, 3) != 0);
      wr_data = words[idx];
      if (poke && idx == 1) begin
        cmd_valid = 1; cmd_op = 1; cmd_count = 5;
      end else if (poke) cmd_valid = 0;
      @(negedge CPU_CLK);
      hs = wr_valid && wr_ready;
      if (cmd_valid) chk("busy_cmd_ready", cmd_ready, 0);
      @(posedge CPU_CLK); #1;
      cyc++;
      if (hs) idx++;
    end
    wr_valid = 0; cmd_valid = 0;
    if (idx < count) chk("load_timeout", idx, count);
    wait_idle();
  endtask

  task automatic dump(input logic sel, input logic [31:0] base, input int count,
                      input int stall, input bit rnd);
    int n = 0, cyc = 0;
    cap_a.delete(); cap_d.delete();
    send_cmd(1, sel, base, count);
    while (n < count && cyc < 20 * count + 40) begin
      rd_ready = (cyc >= stall) && (!rnd || $urandom_range(0, 2) != 0);
      @(negedge CPU_CLK);
      if (rd_valid && rd_ready) begin
        cap_a.push_back(rd_addr);
        cap_d.push_back(rd_data);
        n++;
      end
      @(posedge CPU_CLK); #1;
      cyc++;
    end
    rd_ready = 0;
    if (n < count) chk("dump_timeout", n, count);
    wait_idle();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    logic op, sel;
    int cnt;
    #2;
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_flags", {busy, done, core_rst_hold, wr_ready, rd_valid}, 0);
    chk("rst_rd", rd_data | rd_addr, 0);
    chk("rst_ports", dram_a2 | iram_a2 | dram_wd2 | iram_wd2 | {24'b0, dram_we2, iram_we2}, 0);
    repeat (2) @(posedge CPU_CLK);
    #1 CPU_RST = 0;
    @(posedge CPU_CLK); #1;

    words = '{32'hA1, 32'hB2, 32'hC3};
    load(0, 32'h10, 3, 1, 0, cyc);
    chk("t1_cycles", cyc, 3);
    chk("t1_w0", ram_d[4], 32'hA1);
    chk("t1_w1", ram_d[5], 32'hB2);
    chk("t1_w2", ram_d[6], 32'hC3);
    chk("t1_iram_untouched", ram_i[4], init_word(1, 4));

    words = '{32'h11111111, 32'h22222222};
    load(1, 32'h20, 2, 1, 0, cyc);
    dump(1, 32'h20, 2, 0, 0);
    chk("t2_a0", cap_a[0], 32'h20);
    chk("t2_d0", cap_d[0], 32'h11111111);
    chk("t2_a1", cap_a[1], 32'h24);
    chk("t2_d1", cap_d[1], 32'h22222222);

    dump(0, 32'h10, 2, 8, 0);
    chk("t3_d0", cap_d[0], 32'hA1);
    chk("t3_a1", cap_a[1], 32'h14);
    chk("t3_d1", cap_d[1], 32'hB2);

    words = '{32'hFACE0001, 32'hFACE0002};
    load(0, 32'h3FFE, 2, 1, 0, cyc);
    chk("t4_hi", ram_d[4095], 32'hFACE0001);
    chk("t4_lo", ram_d[0], 32'hFACE0002);
    dump(0, 32'h3FFC, 2, 0, 0);
    chk("t4_a0", cap_a[0], 32'h3FFC);
    chk("t4_a1", cap_a[1], 32'h0);

    send_cmd(0, 0, 32'h40, 0);
    chk("t5_done", done, 1);
    @(posedge CPU_CLK); #1;
    chk("t5_idle", {done, busy}, 0);
    words = '{32'h5, 32'h6, 32'h7, 32'h8};
    load(0, 32'h200, 4, 0, 1, cyc);
    chk("t5_load_w3", ram_d[32'h83], 32'h8);

    send_cmd(0, 0, 32'h100, 4);
    wr_valid = 1; wr_data = 32'hDEADBEEF;
    @(negedge CPU_CLK);
    @(posedge CPU_CLK); #3;
    CPU_RST = 1;
    #1;
    chk("t6_flags", {busy, done, core_rst_hold, wr_ready}, 0);
    chk("t6_cmd_ready", cmd_ready, 1);
    chk("t6_ports", dram_a2 | dram_wd2 | {28'b0, dram_we2}, 0);
    wr_valid = 0;
    @(posedge CPU_CLK); #1;
    CPU_RST = 0;
    chk("t6_written", ram_d[64], 32'hDEADBEEF);
    chk("t6_unwritten", ram_d[65], init_word(0, 65));
    @(posedge CPU_CLK); #1;
    chk("t6_no_done", done, 0);

    for (int k = 0; k < 30; k++) begin
      op = 1'($urandom_range(0, 1));
      sel = 1'($urandom_range(0, 1));
      cnt = $urandom_range(0, 6);
      if (!op) begin
        words.delete();
        for (int i = 0; i < cnt; i++) words.push_back($urandom);
        load(sel, $urandom_range(0, 16383), cnt, 0, 0, cyc);
      end else dump(sel, $urandom_range(0, 16383), cnt, $urandom_range(0, 3), 1);
    end

    words.delete();
    for (int i = 0; i < 4100; i++) words.push_back($urandom);
    load(1, 32'h3FF0, 4100, 0, 0, cyc);
    dump(1, 32'h3FF0, 6, 0, 1);
    chk("t7_overwrite", cap_d[0], words[4096]);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/debug_ram_sequencer.md
Name: debug_ram_sequencer

Overview:
Synthesizable loader/dumper that drives the core's second (debug) BRAM ports, CPU_Debug_DataRAM_* and CPU_Debug_InstRAM_*. It replaces bench-side $readmemh loads and address-stepping dump loops, so on-board bring-up can preload and read back both RAMs over a word stream. It sits directly upstream of RV32Core's debug ports. It also holds the core in reset while a load is in progress.

Parameters:
WORDS, 4096, BRAM depth in 32-bit words; byte addresses wrap modulo 4*WORDS
CNT_W, 13, width of the word-count field; must hold the value WORDS

Ports:
CPU_CLK  in  1  clock; all logic is on the rising edge
CPU_RST  in  1  reset, asynchronous, active-high
cmd_valid  in  1  command request
cmd_ready  out  1  high only in IDLE
cmd_op  in  1  0 = load (write RAM), 1 = dump (read RAM)
cmd_sel  in  1  0 = data RAM, 1 = instruction RAM
cmd_base  in  32  start byte address; bits [1:0] are ignored and forced to 0
cmd_count  in  CNT_W  number of words to transfer
wr_valid  in  1  load stream word valid
wr_ready  out  1  load stream accept
wr_data  in  32  load stream word
rd_valid  out  1  dump stream word valid
rd_ready  in  1  dump stream accept
rd_data  out  32  dumped word
rd_addr  out  32  byte address of rd_data
dram_a2  out  32  to CPU_Debug_DataRAM_A2
dram_wd2  out  32  to CPU_Debug_DataRAM_WD2
dram_we2  out  4  to CPU_Debug_DataRAM_WE2
dram_rd2  in  32  from CPU_Debug_DataRAM_RD2; read latency is 1 cycle
iram_a2  out  32  to CPU_Debug_InstRAM_A2
iram_wd2  out  32  to CPU_Debug_InstRAM_WD2
iram_we2  out  4  to CPU_Debug_InstRAM_WE2
iram_rd2  in  32  from CPU_Debug_InstRAM_RD2; read latency is 1 cycle
core_rst_hold  out  1  ORed into the core's CPU_RST by the top level
busy  out  1  high whenever the state is not IDLE
done  out  1  one-cycle pulse when a command completes

Behaviour:
- Reset (asynchronous, any state):
  - state goes to IDLE.
  - All outputs are 0, except cmd_ready = 1.
  - An in-flight command is aborted, with no done pulse; RAM contents already written stay as written.
- States: IDLE, LOAD, DUMP_ADDR, DUMP_WAIT, DUMP_OUT, FIN.
- IDLE:
  - cmd_valid && cmd_ready latches op, sel, base & ~3, and count; the next state is decided on that edge.
  - count == 0 goes to FIN, touching no RAM.
  - op = 0 goes to LOAD; op = 1 goes to DUMP_ADDR.
- LOAD:
  - wr_ready = 1.
  - On wr_valid && wr_ready, in the same cycle: the selected RAM gets a2 = current address, wd2 = wr_data, we2 = 4'b1111.
  - The address then advances by 4 and the remaining count decrements.
  - When the last word is accepted, go to FIN.
  - we2 is 0 in any cycle without a handshake.
  - core_rst_hold = 1 throughout LOAD.
- DUMP_ADDR: drive a2 = current address with we2 = 0, then go to DUMP_WAIT.
- DUMP_WAIT: hold a2. At the end of this cycle, capture the selected rd2 into rd_data and the address into rd_addr, then go to DUMP_OUT.
- DUMP_OUT:
  - rd_valid = 1; rd_data and rd_addr are stable until the handshake.
  - On rd_ready: advance the address by 4 and decrement the count.
  - If the count reaches 0, go to FIN; otherwise go to DUMP_ADDR.
  - Minimum throughput is 3 cycles per word.
- FIN: done = 1 for one cycle, then go to IDLE. core_rst_hold drops to 0 when FIN is entered.
- Address wrap: next = (addr + 4) mod (4*WORDS). Example: with WORDS = 4096, 0x3FFC is followed by 0x0000.
- Unselected RAM port: a2 = 0, wd2 = 0, we2 = 0 at all times.
- Selected RAM port: wd2 = 0 whenever we2 = 0.
- New commands are ignored while busy (cmd_ready = 0).
- cmd_count larger than WORDS is legal; the address simply wraps and later words overwrite or re-read earlier ones.

Test Plan:
- Load, data RAM: sel = 0, base 0x10, count 3, words A1, B2, C3 with wr_valid held high -> three consecutive cycles of dram_we2 = F at addresses 0x10, 0x14, 0x18; core_rst_hold high during those cycles; done 1 cycle after the last write; iram_we2 stays 0.
- Dump, inst RAM: preload 0x20 = 11111111 and 0x24 = 22222222; dump sel = 1, base 0x20, count 2, rd_ready = 1 -> rd_data/rd_addr = 11111111/0x20, then 22222222/0x24; done pulses once.
- Backpressure: dump count 2 with rd_ready low for 5 cycles -> rd_valid, rd_data and rd_addr stay stable; no address advance until rd_ready.
- Wrap and alignment: base 0x3FFE (forced to 0x3FFC), count 2, load -> writes at 0x3FFC, then 0x0000.
- Zero count and busy: count 0 -> done 1 cycle after the handshake, no RAM activity; cmd_valid asserted during a busy load is ignored (cmd_ready = 0).
- Reset mid-load: assert CPU_RST after 1 of 4 words -> outputs zero immediately (asynchronous), no done pulse; the written word persists; cmd_ready = 1 after reset.
